// File: rtl/manquehuito_pkg.sv
// Shared types and constants for the fetch stage in front of the 256x15 instruction ROM.
package manquehuito_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 15;

  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // One decoded-ready packet: the word and the address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/instruction_fetch_program_counter.sv
// Program counter register: load has priority over increment, otherwise holds.
// The increment wraps naturally at 2^ADDR_W with no flag.
module program_counter #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: redirect target, sequential successor, or unchanged.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_addr_i;
    end else if (inc_i) begin
      pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  // PC register with synchronous reset to the boot address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives the async ROM address from the PC, registers the returned
// word together with its address, and offers it to decode over valid/ready.
// Handles jump redirect, backpressure, halt and restart-by-jump.
module instruction_fetch #(
  parameter int                ADDR_W   = manquehuito_pkg::ADDR_W,
  parameter int                INSTR_W  = manquehuito_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = manquehuito_pkg::RESET_PC
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  input  logic               jump_en_i,
  input  logic [ADDR_W-1:0]  jump_addr_i,
  input  logic               halt_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               halted_o
);

  import manquehuito_pkg::*;

  fetch_state_e state_q;
  fetch_state_e state_d;
  fetch_pkt_t   pkt_q;
  fetch_pkt_t   pkt_d;
  logic         valid_q;
  logic         valid_d;

  logic              pc_load;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc_cur;
  logic              slot_free;

  program_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (pc_load),
    .load_addr_i (jump_addr_i),
    .inc_i       (pc_inc),
    .pc_o        (pc_cur)
  );

  // The output slot can take a new word when empty or being drained this cycle.
  assign slot_free = !valid_q || ready_i;

  // FSM and output-slot control; a jump squashes the slot even if it transfers now.
  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    valid_d = valid_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (jump_en_i) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
        end else if (halt_i) begin
          state_d = HALT;
          valid_d = valid_q && !ready_i;
        end else if (slot_free) begin
          pkt_d.pc    = pc_cur;
          pkt_d.instr = imem_data_i;
          valid_d     = 1'b1;
          pc_inc      = 1'b1;
        end
      end
      HALT: begin
        if (jump_en_i) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
          state_d = RUN;
        end else begin
          valid_d = valid_q && !ready_i;
        end
      end
      default: begin
        state_d = BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output register; reset clears the slot even mid-handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      pkt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr_o = pc_cur;
  assign instr_o     = pkt_q.instr;
  assign pc_o        = pkt_q.pc;
  assign valid_o     = valid_q;
  assign halted_o    = (state_q == HALT);

endmodule
